// File: rtl/trap_pkg.sv
// Shared trap sequencer types: FSM state encoding, exception cause codes and drain length.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_SAVE     = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;
    localparam logic [3:0] CAUSE_MEI        = 4'd11;

    localparam logic [1:0] DRAIN_CYCLES = 2'd2;

endpackage

// File: rtl/trap_sequencer.sv
// Sequences exceptions, mret and (with TRAP_IRQ_EN) external interrupts: drain, CSR save, fetch redirect.
// Idle: hazard controls pass through combinationally; busy: overrides them (trap 5 cycles, mret 2).
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exc_valid_e,
    input  logic [3:0]      exc_cause_e,
    input  logic            mret_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic            irq_ext,
    input  logic            mstatus_mie,
    input  logic            mie_meie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            stall_f_hz,
    input  logic            stall_d_hz,
    input  logic            flush_d_hz,
    input  logic            flush_e_hz,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e,
    output logic            flush_m,
    output logic            trap_redirect,
    output logic [XLEN-1:0] trap_pc,
    output logic            csr_mepc_we,
    output logic [XLEN-1:0] csr_mepc_wdata,
    output logic            csr_mcause_we,
    output logic [XLEN-1:0] csr_mcause_wdata,
    output logic            csr_mstatus_trap,
    output logic            csr_mstatus_mret,
    output logic            busy
);

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [3:0]      cause_q, cause_d;
    logic            irq_q, irq_d;
    logic            mret_q, mret_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            irq_take;

`ifdef TRAP_IRQ_EN
    assign irq_take = irq_ext & mstatus_mie & mie_meie;
    logic unused_cfg;
    assign unused_cfg = ^mtvec[1:0];
`else
    assign irq_take = 1'b0;
    logic unused_cfg;
    assign unused_cfg = ^{irq_ext, mstatus_mie, mie_meie, mtvec[1:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            irq_q   <= 1'b0;
            mret_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            irq_q   <= irq_d;
            mret_q  <= mret_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        epc_d            = epc_q;
        cause_d          = cause_q;
        irq_d            = irq_q;
        mret_d           = mret_q;
        cnt_d            = cnt_q;
        stall_f          = 1'b0;
        stall_d          = 1'b0;
        flush_d          = 1'b0;
        flush_e          = 1'b0;
        flush_m          = 1'b0;
        trap_redirect    = 1'b0;
        trap_pc          = '0;
        csr_mepc_we      = 1'b0;
        csr_mepc_wdata   = '0;
        csr_mcause_we    = 1'b0;
        csr_mcause_wdata = '0;
        csr_mstatus_trap = 1'b0;
        csr_mstatus_mret = 1'b0;
        busy             = 1'b0;

        // Outputs are forced low for the whole time reset is held, not just after the edge.
        if (rst_n) begin
            busy = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (exc_valid_e || mret_e || irq_take) begin
                        // Kill the Execute instruction and freeze fetch/decode; any branch flush is dropped.
                        epc_d   = pc_e;
                        flush_m = 1'b1;
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                        cnt_d   = DRAIN_CYCLES - 2'd1;
                        if (exc_valid_e) begin
                            cause_d = exc_cause_e;
                            irq_d   = 1'b0;
                            mret_d  = 1'b0;
                            state_d = ST_DRAIN;
                        end else if (mret_e) begin
                            mret_d  = 1'b1;
                            state_d = ST_REDIRECT;
                        end else begin
                            cause_d = CAUSE_MEI;
                            irq_d   = 1'b1;
                            mret_d  = 1'b0;
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        stall_f = stall_f_hz;
                        stall_d = stall_d_hz;
                        flush_d = flush_d_hz;
                        flush_e = flush_e_hz;
                    end
                end
                ST_DRAIN: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = ST_SAVE;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                ST_SAVE: begin
                    stall_f          = 1'b1;
                    stall_d          = 1'b1;
                    flush_e          = 1'b1;
                    csr_mepc_we      = 1'b1;
                    csr_mepc_wdata   = epc_q;
                    csr_mcause_we    = 1'b1;
                    csr_mcause_wdata = {irq_q, {(XLEN-5){1'b0}}, cause_q};
                    csr_mstatus_trap = 1'b1;
                    state_d          = ST_REDIRECT;
                end
                ST_REDIRECT: begin
                    trap_redirect    = 1'b1;
                    flush_d          = 1'b1;
                    flush_e          = 1'b1;
                    trap_pc          = mret_q ? mepc : {mtvec[XLEN-1:2], 2'b00};
                    csr_mstatus_mret = mret_q;
                    state_d          = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle controller that sequences synchronous exceptions, `mret`, and optional machine external interrupts through the 5-stage pipeline. It sits beside the hazard unit and receives that unit's stall and flush outputs. While a trap is in progress it overrides them, drains older instructions, issues CSR updates (`mepc`, `mcause`, `mstatus`), and redirects fetch to `mtvec` or `mepc`. When idle it passes the hazard controls through unchanged.

## Interface
- `XLEN`, 32, datapath/PC width

- `clk` in 1: pipeline clock
- `rst_n` in 1: asynchronous active-low reset
- `exc_valid_e` in 1: instruction in Execute raised an exception (illegal, ecall, ebreak)
- `exc_cause_e` in 4: exception code for that instruction
- `mret_e` in 1: instruction in Execute is `mret`
- `pc_e` in XLEN: PC of the instruction in Execute
- `irq_ext` in 1: machine external interrupt request, level
- `mstatus_mie` in 1: global interrupt enable
- `mie_meie` in 1: external interrupt enable
- `mtvec` in XLEN: trap vector CSR value
- `mepc` in XLEN: exception PC CSR value
- `stall_f_hz`, `stall_d_hz`, `flush_d_hz`, `flush_e_hz` in 1 each: hazard-unit controls
- `stall_f`, `stall_d`, `flush_d`, `flush_e`, `flush_m` out 1 each: final pipeline controls
- `trap_redirect` out 1: take `trap_pc` as next PC, overriding the branch target
- `trap_pc` out XLEN: redirect target
- `csr_mepc_we` out 1, `csr_mepc_wdata` out XLEN
- `csr_mcause_we` out 1, `csr_mcause_wdata` out XLEN
- `csr_mstatus_trap` out 1: MPIE←MIE, MIE←0
- `csr_mstatus_mret` out 1: MIE←MPIE, MPIE←1
- `busy` out 1: FSM not in IDLE

## Operation
- **States:** IDLE, DRAIN, SAVE, REDIRECT.
- **Event priority in IDLE:** `exc_valid_e` > `mret_e` > interrupt (`irq_ext & mstatus_mie & mie_meie`).
- **Accept cycle** (IDLE with any event):
  - Capture `pc_e` into `epc_q`, and capture the cause.
  - Assert `flush_m` so the Execute instruction never commits. The trapping instruction, `mret`, and the interrupted instruction are all killed; the interrupted instruction re-executes after `mret`.
  - Assert `stall_f=stall_d=flush_e=1`.
- **Exception or interrupt path:** IDLE → DRAIN.
- **`mret` path:** IDLE → REDIRECT.
- **DRAIN:**
  - A 2-bit counter runs `DRAIN_CYCLES`=2 cycles so older instructions in M/W retire.
  - Hold `stall_f=stall_d=flush_e=1`.
  - Advance to SAVE when the counter reaches 0.
- **SAVE:** one cycle.
  - `csr_mepc_we=1`, `csr_mepc_wdata=epc_q`.
  - `csr_mcause_we=1`, `csr_mcause_wdata={irq_q, {XLEN-5{1'b0}}, cause_q}`.
  - `csr_mstatus_trap=1`.
  - Stalls held.
- **REDIRECT:** one cycle.
  - `trap_redirect=1`, `flush_d=flush_e=1`.
  - `trap_pc={mtvec[XLEN-1:2],2'b00}` for a trap. For `mret`, `trap_pc=mepc`, and `csr_mstatus_mret=1` is asserted in the same cycle.
  - Next state IDLE.
- **Pass-through:** in IDLE with no event, outputs equal the `*_hz` inputs, and `flush_m=0`, `trap_redirect=0`, `trap_pc=0`.
- **Events while busy:** new events are ignored; the pipeline is stalled or flushed, so none can be valid.

## Timing
- **Reset:** all outputs 0; state IDLE; `epc_q`, `cause_q`, `irq_q`, and the counter cleared. Reset is asynchronous and may occur in any state. Partially issued CSR writes are not replayed.
- **Exception or interrupt at cycle T (IDLE):**
  - DRAIN at T+1 and T+2.
  - SAVE at T+3.
  - REDIRECT at T+4.
  - IDLE at T+5, when the first handler fetch enters Decode.
- **`mret` at T:** REDIRECT at T+1, IDLE at T+2.
- **Simultaneous events:** an exception in the same cycle as a hazard branch flush (PCSrcE reflected in `flush_d_hz`) wins; the branch is discarded. An exception in the same cycle as a load-use stall is still accepted.
- **Interrupt deassertion:** `irq_ext` dropping after acceptance does not abort the sequence.
- **Registered outputs:** CSR write enables are registered-state decodes, active for exactly one cycle.

## Configuration
- `TRAP_IRQ_EN` defined:
  - The interrupt path is compiled in.
  - `mcause[XLEN-1]=1` and code 11 for an external interrupt.
- Not defined:
  - `irq_ext`, `mstatus_mie`, and `mie_meie` remain ports but are ignored.
  - `irq_q` is tied to 0.
  - Only exceptions and `mret` are sequenced.

## Structure
- **Shared package `trap_pkg`:** the state enum; cause constants (`CAUSE_ILLEGAL`=2, `CAUSE_BREAKPOINT`=3, `CAUSE_ECALL_M`=11, `CAUSE_MEI`=11); `DRAIN_CYCLES`=2.
- **Sub-modules:** none required. The drain counter and the override mux stay inline.

## Test plan
- **Idle pass-through:** random `*_hz` values, no events → outputs mirror the inputs every cycle, and `busy=0`.
- **ecall:** `exc_valid_e=1`, cause 11, `pc_e=0x100`, `mtvec=0x205` at T → `flush_m` at T; `mepc` write of 0x100 and `mcause` write of 0x0000000B at T+3; `trap_redirect` with `trap_pc=0x204` at T+4; `busy=0` at T+5.
- **mret:** `mret_e=1`, `mepc=0x104` at T → `trap_redirect`, `trap_pc=0x104`, and `csr_mstatus_mret` at T+1; no CSR write enables.
- **Priority:** `exc_valid_e`, `mret_e`, and `irq_ext` (enabled) asserted together → exception sequence runs and `mcause[31]=0`. Separately, an exception together with `flush_d_hz=1` → redirect goes to `mtvec`.
- **Interrupt (`TRAP_IRQ_EN` defined):** `irq_ext=1`, `mstatus_mie=1`, `mie_meie=1`, `pc_e=0x40` → `mepc=0x40` and `mcause=0x8000000B`. With `mstatus_mie=0` → no action.
- **Reset mid-sequence:** `rst_n` low during SAVE → all outputs 0 immediately; after release, the FSM is in IDLE with no pending CSR write.
